// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns 'W'/'R' command frames from the UART receiver into SDRAM requests
// and returns either the read word (high byte first) or an acknowledge byte to the transmitter.
module uart_cmd_parser #(
   parameter int         ADDR_W         = 24,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter logic [7:0] ACK_BYTE       = 8'h4B
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [15:0]       cmd_wdata,
   input  logic              rd_valid,
   input  logic [15:0]       rd_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              busy,
   output logic              err_pulse
);
   localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, ISSUE, WAIT_RD, TX_HI, TX_LO, TX_ACK} state_t;
   state_t        state;
   logic [1:0]    nbyte;
   logic [TW-1:0] tcnt;
   logic [23:0]   addr_q;
   logic [7:0]    rd_lo;
   logic          timing, taken, abort, overrun;
   assign cmd_addr = addr_q[ADDR_W-1:0];
   assign timing   = state inside {ADDR, WDATA, WAIT_RD};
   assign taken    = state == WAIT_RD ? rd_valid : rx_valid;
   assign abort    = timing && tcnt == TW'(TIMEOUT_CYCLES - 1) && !taken;
   assign overrun  = rx_valid && state inside {ISSUE, WAIT_RD, TX_HI, TX_LO, TX_ACK};
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         nbyte     <= '0;
         tcnt      <= '0;
         addr_q    <= '0;
         rd_lo     <= '0;
         cmd_valid <= 1'b0;
         cmd_write <= 1'b0;
         cmd_wdata <= '0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         tcnt      <= timing ? tcnt + 1'b1 : '0;
         err_pulse <= overrun;
         case (state)
            IDLE: if (rx_valid) begin
               if (rx_data == 8'h57 || rx_data == 8'h52) begin
                  cmd_write <= rx_data == 8'h57;
                  nbyte     <= '0;
                  busy      <= 1'b1;
                  state     <= ADDR;
               end else err_pulse <= 1'b1;
            end
            ADDR: if (rx_valid) begin
               addr_q <= {addr_q[15:0], rx_data};
               tcnt   <= '0;
               nbyte  <= nbyte == 2'd2 ? 2'd0 : nbyte + 2'd1;
               if (nbyte == 2'd2) begin
                  state     <= cmd_write ? WDATA : ISSUE;
                  cmd_valid <= !cmd_write;
               end
            end
            WDATA: if (rx_valid) begin
               cmd_wdata <= {cmd_wdata[7:0], rx_data};
               tcnt      <= '0;
               nbyte     <= nbyte == 2'd1 ? 2'd0 : nbyte + 2'd1;
               if (nbyte == 2'd1) begin
                  state     <= ISSUE;
                  cmd_valid <= 1'b1;
               end
            end
            ISSUE: if (cmd_ready) begin
               cmd_valid <= 1'b0;
               tcnt      <= '0;
               state     <= cmd_write ? TX_ACK : WAIT_RD;
               if (cmd_write) begin
                  tx_valid <= 1'b1;
                  tx_data  <= ACK_BYTE;
               end
            end
            WAIT_RD: if (rd_valid) begin
               rd_lo    <= rd_data[7:0];
               tx_data  <= rd_data[15:8];
               tx_valid <= 1'b1;
               tcnt     <= '0;
               state    <= TX_HI;
            end
            TX_HI: if (tx_ready) begin
               tx_data <= rd_lo;
               state   <= TX_LO;
            end
            TX_LO, TX_ACK: if (tx_ready) begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // a byte or read word arriving on the terminal count wins over the timeout
         if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tcnt      <= '0;
            err_pulse <= 1'b1;
         end
      end
   end
endmodule
